cache_feed_fifo: RTL
====================

// Module: cache_feed_fifo
// PURPOSE
//   Byte-stream FIFO that sits directly upstream of CacheWithInterface.
//   It absorbs bursty producer traffic and presents one byte per cycle on the
//   cache dataIn lane, using valid/ready handshakes on both sides.
//   It also keeps a saturating count of producer beats refused while full,
//   for debug.
// PARAMETERS
//   WIDTH  8  data width in bits; matches the cache dataIn lane
//   DEPTH  4  number of entries; must be a power of two and >= 2
//   AW     2  pointer width = log2(DEPTH); the instantiating module sets it
// PORTS
//   clock       in   1        rising-edge clock for all state
//   clear       in   1        synchronous active-high reset
//   in_data     in   WIDTH    producer byte
//   in_valid    in   1        producer beat valid
//   in_ready    out  1        FIFO can accept a beat this cycle
//   out_data    out  WIDTH    head byte; drives cache dataIn
//   out_valid   out  1        head byte valid (FIFO not empty)
//   out_ready   in   1        consumer takes head this cycle
//   count       out  AW+1     current occupancy, 0..DEPTH
//   drop_count  out  8        beats refused (in_valid & ~in_ready); saturates at 8'hff
// BEHAVIOUR
// - Reset: on a clock edge with clear=1, wr_ptr, rd_ptr and count go to 0, and
//   drop_count goes to 0.
//   - Storage contents are don't-care after reset.
//   - Outputs in the cycle after clear: out_valid=0, out_data=0, in_ready=1.
//   - While clear=1: in_ready=0 and no push, pop or drop is recorded.
//   - Clear overrides any handshake in the same cycle.
// - push = in_valid & in_ready; pop = out_valid & out_ready. Both are evaluated
//   on the same edge.
// - in_ready = ~clear & (count != DEPTH).
//   - A full FIFO refuses a push even if a pop happens in the same cycle.
//   - The refused beat is counted as a drop; the producer must hold it and retry.
// - out_valid = (count != 0).
// - out_data = mem[rd_ptr] when out_valid=1, else WIDTH'b0. It is combinational
//   from registered state, so there is no extra output register.
// - Latency: a byte pushed into an empty FIFO at edge N appears on out_data with
//   out_valid=1 after edge N. That is 1 cycle; there is no same-cycle bypass.
// - Push writes mem[wr_ptr], then wr_ptr <= wr_ptr+1 (mod DEPTH).
// - Pop advances rd_ptr <= rd_ptr+1 (mod DEPTH). Pointers wrap naturally at AW bits.
// - count update:
//   - +1 on push only
//   - -1 on pop only
//   - unchanged on push and pop together, or on neither
// - Push and pop together at 0 < count < DEPTH: count holds and both pointers
//   advance. The popped byte is the old head, never the byte being pushed.
// - drop_count increments when in_valid & ~in_ready & ~clear. It holds at
//   8'hff once reached.
// - out_ready while empty, or in_valid while full, is legal and has no effect
//   other than the drop count.
// - Data order is strictly FIFO: no reordering, duplication or loss of
//   accepted beats.
// TESTING
// 1. Clear for 4 cycles, then release
//    -> count=0, out_valid=0, out_data=00, in_ready=1, drop_count=00.
// 2. out_ready=0; push 11,22,33,44 on consecutive cycles; hold in_valid with 55
//    -> count=4, in_ready=0, drop_count increments each held cycle,
//       out_data=11 throughout.
// 3. From the full state of test 2, out_ready=1, in_valid=0 for 4 cycles
//    -> out_data 11,22,33,44 on successive cycles, then out_valid=0, out_data=00.
// 4. count=2 with head AA; push BB and pop together
//    -> count stays 2, popped byte=AA, later pops give the remaining entry then BB.
// 5. Stream 00..ff with in_valid=1 and out_ready=1 throughout
//    -> out_data sequence 00..ff lagging in_data by 1 cycle, count<=1,
//       drop_count=00, pointers wrap 64 times with no glitch.
// 6. Assert clear for 1 cycle mid-stream with count=3 and in_valid=1
//    -> next cycle count=0, out_valid=0, drop_count=00, the byte offered
//       during clear is not stored.
// 7. Connect out_data to CacheWithInterface dataIn and stream 00..ff
//    -> ~dataOut matches the previously accepted byte each cycle.
// 8. Hold the FIFO full with in_valid=1 for 300 cycles
//    -> drop_count saturates at ff and stays at ff.

Source files
------------

// File: rtl/cache_feed_fifo_if.sv
// Handshake bundle between a byte producer, the feed FIFO and the cache dataIn lane.
// The master side drives the producer beats and the consumer ready. The slave side is the FIFO.
interface cache_feed_fifo_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [AW:0]      count;
  logic [7:0]       drop_count;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count, drop_count
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count, drop_count
  );
endinterface

// File: rtl/cache_feed_fifo.sv
// Byte FIFO in front of the cache dataIn lane, with valid/ready on both sides.
// It also keeps a saturating count of producer beats refused while the FIFO is full.
module cache_feed_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic            clock,
  input  logic            clear,
  cache_feed_fifo_if.slave bus
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [7:0]       drop_q, drop_d;
  logic             in_ready, out_valid, push, pop;

  // A full FIFO refuses a beat even when a pop lands on the same edge.
  always_comb begin
    in_ready  = ~clear & (count_q != FULL_CNT);
    out_valid = (count_q != '0);
    push      = bus.in_valid & in_ready;
    pop       = out_valid & bus.out_ready & ~clear;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.in_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (bus.in_valid & ~in_ready & ~clear & (drop_q != 8'hff))
      drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset because out_valid masks any stale entry.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_comb begin
    bus.in_ready   = in_ready;
    bus.out_valid  = out_valid;
    bus.out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    bus.count      = count_q;
    bus.drop_count = drop_q;
  end
endmodule
